// File: rtl/mips_mc_controller_p.sv
// Multi-cycle MIPS control unit with run handshake, memory wait states,
// HALT opcode, illegal-instruction detection and a retired-instruction counter.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_IDLE   | waiting for i_start, status flags hold
// S_FETCH  | instruction read, PC+4; IR/PC load on final wait cycle
// S_DECODE | branch target into ALUOut, dispatch on opcode
// S_RTEXE  | R-type ALU operation selected by func
// S_RTWB   | R-type result write to rd
// S_IEXE   | immediate ALU operation
// S_IWB    | immediate result write to rt
// S_MEMADR | effective address computation for lw/sw
// S_MEMRD  | data read, held for the full access
// S_MEMWB  | loaded data written to rt
// S_MEMWR  | data write, held for the full access
// S_BRANCH | compare and conditional PC load
// S_JUMP   | unconditional PC load from jump target
// S_HALT   | run finished normally
// S_ERROR  | illegal opcode or func, run aborted
module mips_mc_controller_p #(
  parameter int OPCODE_W    = 4,
  parameter int FUNC_W      = 9,
  parameter int ALUOP_W     = 3,
  parameter int MEM_LATENCY = 0,
  parameter int ICNT_W      = 16
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_start,
  input  logic [OPCODE_W-1:0] i_opcode,
  input  logic [FUNC_W-1:0]   i_func,
  output logic                o_mem_read,
  output logic                o_mem_write,
  output logic                o_iord,
  output logic                o_ir_write,
  output logic                o_pc_write,
  output logic                o_pc_write_cond,
  output logic                o_reg_write,
  output logic                o_reg_dst,
  output logic                o_mem_to_reg,
  output logic                o_alu_src_a,
  output logic                o_im_sel,
  output logic [1:0]          o_alu_src_b,
  output logic [1:0]          o_pc_src,
  output logic [ALUOP_W-1:0]  o_alu_op,
  output logic                o_busy,
  output logic                o_done,
  output logic                o_err,
  output logic [ICNT_W-1:0]   o_icnt
);

  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_DECODE, S_RTEXE, S_RTWB, S_IEXE, S_IWB, S_MEMADR,
    S_MEMRD, S_MEMWB, S_MEMWR, S_BRANCH, S_JUMP, S_HALT, S_ERROR
  } state_t;

  localparam logic [3:0] LAT = 4'(MEM_LATENCY);

  localparam logic [3:0] OP_RTYPE = 4'd0;
  localparam logic [3:0] OP_ADDI  = 4'd1;
  localparam logic [3:0] OP_SLTI  = 4'd2;
  localparam logic [3:0] OP_ANDI  = 4'd3;
  localparam logic [3:0] OP_ORI   = 4'd4;
  localparam logic [3:0] OP_LW    = 4'd5;
  localparam logic [3:0] OP_SW    = 4'd6;
  localparam logic [3:0] OP_BEQ   = 4'd7;
  localparam logic [3:0] OP_J     = 4'd8;
  localparam logic [3:0] OP_HALT  = 4'd9;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b100;

  state_t              r_state;
  state_t              w_next;
  logic [3:0]          r_wait;
  logic [3:0]          r_op;
  logic [FUNC_W-1:0]   r_func;
  logic                r_done;
  logic                r_err;
  logic [ICNT_W-1:0]   r_icnt;
  logic                w_last;
  logic                w_func_ok;
  logic [2:0]          w_func_alu;
  logic [2:0]          w_alu;

  // Down-counter at zero marks the final cycle of a memory access.
  assign w_last   = (r_wait == 4'd0);
  assign o_alu_op = ALUOP_W'(w_alu);
  assign o_done   = r_done;
  assign o_err    = r_err;
  assign o_icnt   = r_icnt;

  // Decode the latched one-hot func; bits above the five defined ops must be clear.
  always_comb begin
    w_func_ok  = 1'b0;
    w_func_alu = ALU_ADD;
    if ((r_func & ~FUNC_W'(5'h1f)) == '0) begin
      case (r_func[4:0])
        5'b00001: begin w_func_ok = 1'b1; w_func_alu = ALU_ADD; end
        5'b00010: begin w_func_ok = 1'b1; w_func_alu = ALU_SUB; end
        5'b00100: begin w_func_ok = 1'b1; w_func_alu = ALU_AND; end
        5'b01000: begin w_func_ok = 1'b1; w_func_alu = ALU_OR;  end
        5'b10000: begin w_func_ok = 1'b1; w_func_alu = ALU_SLT; end
        default:  begin w_func_ok = 1'b0; w_func_alu = ALU_ADD; end
      endcase
    end
  end

  // State register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  // Wait-state counter, instruction field capture and run status.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wait <= 4'd0;
      r_op   <= 4'd0;
      r_func <= '0;
      r_done <= 1'b0;
      r_err  <= 1'b0;
      r_icnt <= '0;
    end else begin
      if (w_next != r_state)  r_wait <= LAT;
      else if (r_wait != 4'd0) r_wait <= r_wait - 4'd1;

      if (r_state == S_DECODE) begin
        r_op   <= i_opcode[3:0];
        r_func <= i_func;
      end

      if (r_state == S_IDLE && i_start) begin
        r_done <= 1'b0;
        r_err  <= 1'b0;
        r_icnt <= '0;
      end else begin
        if (w_next == S_HALT) r_done <= 1'b1;
        if (w_next == S_ERROR) begin
          r_done <= 1'b1;
          r_err  <= 1'b1;
        end
        if (r_state == S_FETCH && w_last) r_icnt <= r_icnt + 1'b1;
      end
    end
  end

  // Next state and Moore strobes.
  always_comb begin
    w_next          = r_state;
    o_mem_read      = 1'b0;
    o_mem_write     = 1'b0;
    o_iord          = 1'b0;
    o_ir_write      = 1'b0;
    o_pc_write      = 1'b0;
    o_pc_write_cond = 1'b0;
    o_reg_write     = 1'b0;
    o_reg_dst       = 1'b0;
    o_mem_to_reg    = 1'b0;
    o_alu_src_a     = 1'b0;
    o_im_sel        = 1'b0;
    o_alu_src_b     = 2'b00;
    o_pc_src        = 2'b00;
    w_alu           = ALU_ADD;
    o_busy          = !(r_state inside {S_IDLE, S_HALT, S_ERROR});
    case (r_state)
      S_IDLE: if (i_start) w_next = S_FETCH;
      S_FETCH: begin
        o_mem_read  = 1'b1;
        o_alu_src_b = 2'b01;
        if (w_last) begin
          o_ir_write = 1'b1;
          o_pc_write = 1'b1;
          w_next     = S_DECODE;
        end
      end
      S_DECODE: begin
        o_alu_src_b = 2'b10;
        case (i_opcode[3:0])
          OP_RTYPE:                         w_next = S_RTEXE;
          OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI: w_next = S_IEXE;
          OP_LW, OP_SW:                     w_next = S_MEMADR;
          OP_BEQ:                           w_next = S_BRANCH;
          OP_J:                             w_next = S_JUMP;
          OP_HALT:                          w_next = S_HALT;
          default:                          w_next = S_ERROR;
        endcase
      end
      S_RTEXE: begin
        o_alu_src_a = 1'b1;
        w_alu       = w_func_alu;
        w_next      = w_func_ok ? S_RTWB : S_ERROR;
      end
      S_RTWB: begin
        o_reg_write = 1'b1;
        o_reg_dst   = 1'b1;
        w_next      = S_FETCH;
      end
      S_IEXE: begin
        o_alu_src_a = 1'b1;
        o_alu_src_b = 2'b10;
        o_im_sel    = (r_op == OP_ANDI) || (r_op == OP_ORI);
        case (r_op)
          OP_SLTI: w_alu = ALU_SLT;
          OP_ANDI: w_alu = ALU_AND;
          OP_ORI:  w_alu = ALU_OR;
          default: w_alu = ALU_ADD;
        endcase
        w_next = S_IWB;
      end
      S_IWB: begin
        o_reg_write = 1'b1;
        w_next      = S_FETCH;
      end
      S_MEMADR: begin
        o_alu_src_a = 1'b1;
        o_alu_src_b = 2'b10;
        w_next      = (r_op == OP_LW) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        o_mem_read = 1'b1;
        o_iord     = 1'b1;
        if (w_last) w_next = S_MEMWB;
      end
      S_MEMWB: begin
        o_reg_write  = 1'b1;
        o_mem_to_reg = 1'b1;
        w_next       = S_FETCH;
      end
      S_MEMWR: begin
        o_mem_write = 1'b1;
        o_iord      = 1'b1;
        if (w_last) w_next = S_FETCH;
      end
      S_BRANCH: begin
        o_alu_src_a     = 1'b1;
        w_alu           = ALU_SUB;
        o_pc_write_cond = 1'b1;
        o_pc_src        = 2'b01;
        w_next          = S_FETCH;
      end
      S_JUMP: begin
        o_pc_write = 1'b1;
        o_pc_src   = 2'b10;
        w_next     = S_FETCH;
      end
      S_HALT:  w_next = S_IDLE;
      S_ERROR: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_mips_mc_controller_p.sv
// Bench for mips_mc_controller_p: three instances (latency 0, latency 3,
// 2-bit instruction counter) run the same programs side by side. The bench
// plays the instruction register, loading the next program word on IRWrite.
module tb_mips_mc_controller_p;
  localparam int N_DUT = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       start;
  logic [3:0] opcode        [N_DUT];
  logic [8:0] func          [N_DUT];
  logic       mem_read      [N_DUT];
  logic       mem_write     [N_DUT];
  logic       iord          [N_DUT];
  logic       ir_write      [N_DUT];
  logic       pc_write      [N_DUT];
  logic       pc_write_cond [N_DUT];
  logic       reg_write     [N_DUT];
  logic       reg_dst       [N_DUT];
  logic       mem_to_reg    [N_DUT];
  logic       alu_src_a     [N_DUT];
  logic       im_sel        [N_DUT];
  logic [1:0] alu_src_b     [N_DUT];
  logic [1:0] pc_src        [N_DUT];
  logic [2:0] alu_op        [N_DUT];
  logic       busy          [N_DUT];
  logic       done          [N_DUT];
  logic       err           [N_DUT];
  logic [15:0] icnt         [N_DUT];

  for (genvar g = 0; g < N_DUT; g++) begin : g_dut
    localparam int LAT = (g == 1) ? 3 : 0;
    localparam int IW  = (g == 2) ? 2 : 16;
    logic [IW-1:0] icnt_l;
    mips_mc_controller_p #(
      .OPCODE_W(4), .FUNC_W(9), .ALUOP_W(3), .MEM_LATENCY(LAT), .ICNT_W(IW)
    ) u_dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_start(start),
      .i_opcode(opcode[g]), .i_func(func[g]),
      .o_mem_read(mem_read[g]), .o_mem_write(mem_write[g]), .o_iord(iord[g]),
      .o_ir_write(ir_write[g]), .o_pc_write(pc_write[g]),
      .o_pc_write_cond(pc_write_cond[g]), .o_reg_write(reg_write[g]),
      .o_reg_dst(reg_dst[g]), .o_mem_to_reg(mem_to_reg[g]),
      .o_alu_src_a(alu_src_a[g]), .o_im_sel(im_sel[g]),
      .o_alu_src_b(alu_src_b[g]), .o_pc_src(pc_src[g]), .o_alu_op(alu_op[g]),
      .o_busy(busy[g]), .o_done(done[g]), .o_err(err[g]), .o_icnt(icnt_l)
    );
    assign icnt[g] = 16'(icnt_l);
  end

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  int         exp_cpi [N_DUT][$];
  logic [5:0] exp_ex  [N_DUT][$];
  logic [1:0] exp_wb  [N_DUT][$];
  bit         exp_err [N_DUT];
  int         exp_icnt[N_DUT];
  int         n_wr_exp[N_DUT];
  int         n_wr    [N_DUT];
  int         last_ir [N_DUT];
  bit         have_last[N_DUT];
  bit         prev_irw[N_DUT];
  int         rd_run  [N_DUT];
  int         wr_run  [N_DUT];
  int         idx     [N_DUT];

  logic [3:0] prog_op [8];
  logic [8:0] prog_fn [8];
  int         prog_n;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic int lat(input int g);
    return (g == 1) ? 3 : 0;
  endfunction

  function automatic int iw(input int g);
    return (g == 2) ? 2 : 16;
  endfunction

  // {legal, alu code} for a one-hot R-type func
  function automatic logic [3:0] fn_alu(input logic [8:0] f);
    case (f)
      9'h001:  return 4'b1000;
      9'h002:  return 4'b1001;
      9'h004:  return 4'b1010;
      9'h008:  return 4'b1011;
      9'h010:  return 4'b1100;
      default: return 4'b0000;
    endcase
  endfunction

  function automatic logic [20:0] out_vec(input int g);
    return {mem_read[g], mem_write[g], iord[g], ir_write[g], pc_write[g],
            pc_write_cond[g], reg_write[g], reg_dst[g], mem_to_reg[g],
            alu_src_a[g], im_sel[g], alu_src_b[g], pc_src[g], alu_op[g],
            busy[g], done[g], err[g]};
  endfunction

  task automatic add_ins(input logic [3:0] op, input logic [8:0] fn);
    prog_op[prog_n] = op;
    prog_fn[prog_n] = fn;
    prog_n++;
  endtask

  task automatic reset_mon();
    for (int g = 0; g < N_DUT; g++) begin
      exp_cpi[g].delete();
      exp_ex[g].delete();
      exp_wb[g].delete();
      n_wr_exp[g] = 0; n_wr[g] = 0; have_last[g] = 0; prev_irw[g] = 0;
      rd_run[g] = 0; wr_run[g] = 0; idx[g] = 0; exp_err[g] = 0;
    end
  endtask

  // Build per-instance expectations from the program.
  task automatic load_prog();
    logic [3:0] a;
    int L, c;
    reset_mon();
    for (int g = 0; g < N_DUT; g++) begin
      L = lat(g);
      exp_icnt[g] = prog_n % (1 << iw(g));
      for (int k = 0; k < prog_n; k++) begin
        c = 0;
        case (prog_op[k])
          4'd0: begin
            a = fn_alu(prog_fn[k]);
            if (a[3]) begin
              exp_ex[g].push_back({2'b00, 1'b0, a[2:0]});
              exp_wb[g].push_back(2'b10);
            end else begin
              exp_ex[g].push_back(6'b000000);
              exp_err[g] = 1;
            end
            c = 4 + L;
          end
          4'd1: begin exp_ex[g].push_back(6'b10_0_000); exp_wb[g].push_back(2'b00); c = 4 + L; end
          4'd2: begin exp_ex[g].push_back(6'b10_0_100); exp_wb[g].push_back(2'b00); c = 4 + L; end
          4'd3: begin exp_ex[g].push_back(6'b10_1_010); exp_wb[g].push_back(2'b00); c = 4 + L; end
          4'd4: begin exp_ex[g].push_back(6'b10_1_011); exp_wb[g].push_back(2'b00); c = 4 + L; end
          4'd5: begin exp_ex[g].push_back(6'b10_0_000); exp_wb[g].push_back(2'b01); c = 5 + 2 * L; end
          4'd6: begin exp_ex[g].push_back(6'b10_0_000); n_wr_exp[g]++; c = 4 + 2 * L; end
          4'd7: begin exp_ex[g].push_back(6'b00_0_001); c = 3 + L; end
          4'd8: c = 3 + L;
          4'd9: c = 0;
          default: exp_err[g] = 1;
        endcase
        if (k < prog_n - 1) exp_cpi[g].push_back(c);
      end
    end
  endtask

  // Per-cycle observation of one instance, called just after a negedge.
  task automatic mon(input int g);
    int e;
    logic [5:0] e6;
    logic [1:0] e2;
    if (ir_write[g]) begin
      check_eq($sformatf("irw_pulse[%0d]", g), prev_irw[g], 0);
      check_eq($sformatf("fetch_ctl[%0d]", g),
               {pc_write[g], pc_src[g], mem_read[g], iord[g], alu_src_b[g]}, 7'b1_00_1_0_01);
      if (have_last[g]) begin
        check_eq($sformatf("cpi_pending[%0d]", g), exp_cpi[g].size() != 0, 1);
        if (exp_cpi[g].size() != 0) begin
          e = exp_cpi[g].pop_front();
          check_eq($sformatf("cpi[%0d]", g), cyc - last_ir[g], e);
        end
      end
      last_ir[g] = cyc;
      have_last[g] = 1;
      if (idx[g] < prog_n) begin
        opcode[g] = prog_op[idx[g]];
        func[g]   = prog_fn[idx[g]];
      end
      idx[g]++;
    end
    prev_irw[g] = ir_write[g];
    if (pc_write[g] && !ir_write[g]) check_eq($sformatf("jump_pcsrc[%0d]", g), pc_src[g], 2'b10);
    if (pc_write_cond[g]) check_eq($sformatf("br_pcsrc[%0d]", g), pc_src[g], 2'b01);
    if (alu_src_a[g]) begin
      check_eq($sformatf("ex_pending[%0d]", g), exp_ex[g].size() != 0, 1);
      if (exp_ex[g].size() != 0) begin
        e6 = exp_ex[g].pop_front();
        check_eq($sformatf("ex_ctl[%0d]", g), {alu_src_b[g], im_sel[g], alu_op[g]}, e6);
      end
    end
    if (reg_write[g]) begin
      check_eq($sformatf("wb_pending[%0d]", g), exp_wb[g].size() != 0, 1);
      if (exp_wb[g].size() != 0) begin
        e2 = exp_wb[g].pop_front();
        check_eq($sformatf("wb_ctl[%0d]", g), {reg_dst[g], mem_to_reg[g]}, e2);
      end
    end
    if (mem_read[g]) rd_run[g]++;
    else if (rd_run[g] != 0) begin
      check_eq($sformatf("rd_len[%0d]", g), rd_run[g], lat(g) + 1);
      rd_run[g] = 0;
    end
    if (mem_write[g]) wr_run[g]++;
    else if (wr_run[g] != 0) begin
      check_eq($sformatf("wr_len[%0d]", g), wr_run[g], lat(g) + 1);
      wr_run[g] = 0;
      n_wr[g]++;
    end
  endtask

  task automatic tick();
    @(negedge clk);
    cyc++;
    for (int g = 0; g < N_DUT; g++) mon(g);
  endtask

  function automatic bit all_done();
    return done[0] && done[1] && done[2];
  endfunction

  function automatic bit all_busy();
    return busy[0] && busy[1] && busy[2];
  endfunction

  task automatic run_prog(input string name);
    load_prog();
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 0; c < 300 && !all_done(); c++) begin
      start = (c == 4) && all_busy();
      tick();
    end
    start = 1'b0;
    for (int g = 0; g < N_DUT; g++) begin
      check_eq($sformatf("%s_done[%0d]", name, g), done[g], 1);
      check_eq($sformatf("%s_err[%0d]", name, g), err[g], exp_err[g]);
      check_eq($sformatf("%s_busy[%0d]", name, g), busy[g], 0);
      check_eq($sformatf("%s_icnt[%0d]", name, g), icnt[g], exp_icnt[g]);
      check_eq($sformatf("%s_fetched[%0d]", name, g), idx[g], prog_n);
    end
    repeat (3) tick();
    for (int g = 0; g < N_DUT; g++) begin
      check_eq($sformatf("%s_cpi_left[%0d]", name, g), exp_cpi[g].size(), 0);
      check_eq($sformatf("%s_ex_left[%0d]", name, g), exp_ex[g].size(), 0);
      check_eq($sformatf("%s_wb_left[%0d]", name, g), exp_wb[g].size(), 0);
      check_eq($sformatf("%s_writes[%0d]", name, g), n_wr[g], n_wr_exp[g]);
      check_eq($sformatf("%s_idle_done[%0d]", name, g), {busy[g], done[g]}, 2'b01);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    for (int g = 0; g < N_DUT; g++) begin
      opcode[g] = 4'd0;
      func[g]   = 9'd0;
    end
    reset_mon();
    prog_n = 0;
    #1;
    for (int g = 0; g < N_DUT; g++) begin
      check_eq($sformatf("por_outs[%0d]", g), out_vec(g), 0);
      check_eq($sformatf("por_icnt[%0d]", g), icnt[g], 0);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    tick();
    check_eq("idle_busy", busy[0], 0);

    // add, addi, lw, sw, beq, halt
    prog_n = 0;
    add_ins(4'd0, 9'h001); add_ins(4'd1, 9'h000); add_ins(4'd5, 9'h000);
    add_ins(4'd6, 9'h000); add_ins(4'd7, 9'h000); add_ins(4'd9, 9'h000);
    run_prog("mix");

    // ori, slti, halt
    prog_n = 0;
    add_ins(4'd4, 9'h000); add_ins(4'd2, 9'h000); add_ins(4'd9, 9'h000);
    run_prog("imm");

    // andi, j, sub, and, or, slt, halt
    prog_n = 0;
    add_ins(4'd3, 9'h000); add_ins(4'd8, 9'h000); add_ins(4'd0, 9'h002);
    add_ins(4'd0, 9'h004); add_ins(4'd0, 9'h008); add_ins(4'd0, 9'h010);
    add_ins(4'd9, 9'h000);
    run_prog("alu");

    // illegal opcode
    prog_n = 0;
    add_ins(4'hF, 9'h000);
    run_prog("ill_op");

    // multi-hot func
    prog_n = 0;
    add_ins(4'd0, 9'h003);
    run_prog("ill_fn");

    // reset in the middle of a data read
    prog_n = 0;
    add_ins(4'd5, 9'h000); add_ins(4'd9, 9'h000);
    load_prog();
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 0; c < 50 && !(mem_read[0] && iord[0]); c++) tick();
    check_eq("rst_reach_memrd", {mem_read[0], iord[0]}, 2'b11);
    #2 rst_n = 1'b0;
    #1;
    for (int g = 0; g < N_DUT; g++) begin
      check_eq($sformatf("rst_outs[%0d]", g), out_vec(g), 0);
      check_eq($sformatf("rst_icnt[%0d]", g), icnt[g], 0);
    end
    start = 1'b1;
    repeat (2) @(negedge clk);
    check_eq("rst_start_ignored", out_vec(0), 0);
    start = 1'b0;
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    for (int g = 0; g < N_DUT; g++)
      check_eq($sformatf("post_rst_idle[%0d]", g), out_vec(g), 0);

    // recovery after reset
    prog_n = 0;
    add_ins(4'd0, 9'h001); add_ins(4'd1, 9'h000); add_ins(4'd5, 9'h000);
    add_ins(4'd6, 9'h000); add_ins(4'd7, 9'h000); add_ins(4'd9, 9'h000);
    run_prog("again");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
